seg7_scan_driver: RTL and testbench

Parametrised multi-digit 7-segment scan driver for the board display path. It latches a binary value on a load strobe and shows it in hex, or in decimal after an internal sequential binary-to-BCD conversion. Optional features are leading-zero blanking, a per-digit decimal-point mask and an overflow indication. One instance drives a complete common-anode display group of `NUM_DIGITS` digits through time-multiplexed anode scanning. It replaces per-group fixed 4-digit decoders.

---
 rtl/seg7_scan_driver.sv | 279 +++++++++++++++++++++++++++
 tb/tb_seg7_scan_driver.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
// Multi-digit 7-segment scan driver: hex or decimal (sequential double-dabble) display
// with leading-zero blanking, per-digit decimal points and overflow dashes.
module seg7_scan_driver #(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned SCAN_DIV   = 100000,
    parameter bit          ACTIVE_LOW = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic                    load,
    input  logic                    dec_mode,
    input  logic                    blank_lz,
    input  logic [NUM_DIGITS-1:0]   dp_mask,
    output logic [6:0]              a_to_g,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    dp,
    output logic                    busy,
    output logic                    overflow
);

    localparam int unsigned W  = 4 * NUM_DIGITS;
    localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned CW = $clog2(W);

    localparam logic [6:0] GLYPH_DASH  = 7'h01;
    localparam logic [6:0] GLYPH_BLANK = 7'h00;

    typedef enum logic {
        S_IDLE,
        S_CONV
    } state_e;

    // rst_n is an active-high synchronous reset despite its name
    logic rst;
    assign rst = rst_n;

    state_e               state_q, state_d;
    logic                 hex_commit, conv_start, conv_step, conv_last;

    logic [W-1:0]         bin_q, bin_d;
    logic [W-1:0]         bcd_q, bcd_d;
    logic                 ovf_sh_q, ovf_sh_d;
    logic                 blank_sh_q, blank_sh_d;
    logic [NUM_DIGITS-1:0] dpm_sh_q, dpm_sh_d;
    logic [CW-1:0]        iter_q, iter_d;

    logic [W-1:0]         bcd_adj, bcd_shift;
    logic                 shift_out;

    logic [W-1:0]         digits_q, digits_d;
    logic                 blank_q, blank_d;
    logic [NUM_DIGITS-1:0] dpm_q, dpm_d;
    logic                 ovf_q, ovf_d;

    logic [PW-1:0]        presc_q, presc_d;
    logic [IW-1:0]        idx_q, idx_d;

    logic                 seen;
    logic [NUM_DIGITS-1:0] lead_zero;
    logic [NUM_DIGITS-1:0] sel_oh;
    logic [3:0]           cur_digit;
    logic                 cur_dp, cur_blank;
    logic [6:0]           glyph;

    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic [6:0]           seg_q, seg_d;
    logic                 dp_q, dp_d;

    function automatic logic [6:0] hex_glyph(input logic [3:0] d);
        logic [6:0] g;
        case (d)
            4'h0:    g = 7'h7E;
            4'h1:    g = 7'h30;
            4'h2:    g = 7'h6D;
            4'h3:    g = 7'h79;
            4'h4:    g = 7'h33;
            4'h5:    g = 7'h5B;
            4'h6:    g = 7'h5F;
            4'h7:    g = 7'h70;
            4'h8:    g = 7'h7F;
            4'h9:    g = 7'h7B;
            4'hA:    g = 7'h77;
            4'hB:    g = 7'h1F;
            4'hC:    g = 7'h4E;
            4'hD:    g = 7'h3D;
            4'hE:    g = 7'h4F;
            default: g = 7'h47;
        endcase
        return g;
    endfunction

    // Converter FSM: state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Converter FSM: next state; loads arriving during CONV are dropped
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (load && dec_mode) begin
                    state_d = S_CONV;
                end
            end
            S_CONV: begin
                if (iter_q == CW'(W - 1)) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Converter FSM: control decode
    always_comb begin
        hex_commit = 1'b0;
        conv_start = 1'b0;
        conv_step  = 1'b0;
        conv_last  = 1'b0;
        case (state_q)
            S_IDLE: begin
                hex_commit = load && !dec_mode;
                conv_start = load && dec_mode;
            end
            S_CONV: begin
                conv_step = 1'b1;
                conv_last = (iter_q == CW'(W - 1));
            end
            default: ;
        endcase
    end

    // One double-dabble iteration: add 3 to digits >= 5, then shift the pair left
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
        shift_out = bcd_adj[W-1];
        bcd_shift = {bcd_adj[W-2:0], bin_q[W-1]};
    end

    always_comb begin
        bin_d      = bin_q;
        bcd_d      = bcd_q;
        ovf_sh_d   = ovf_sh_q;
        blank_sh_d = blank_sh_q;
        dpm_sh_d   = dpm_sh_q;
        iter_d     = iter_q;
        if (conv_start) begin
            bin_d      = value;
            bcd_d      = '0;
            ovf_sh_d   = 1'b0;
            blank_sh_d = blank_lz;
            dpm_sh_d   = dp_mask;
            iter_d     = '0;
        end else if (conv_step) begin
            bin_d    = {bin_q[W-2:0], 1'b0};
            bcd_d    = bcd_shift;
            ovf_sh_d = ovf_sh_q | shift_out;
            iter_d   = iter_q + CW'(1);
        end
    end

    // Committed display state; only this bank ever reaches the outputs
    always_comb begin
        digits_d = digits_q;
        blank_d  = blank_q;
        dpm_d    = dpm_q;
        ovf_d    = ovf_q;
        if (hex_commit) begin
            digits_d = value;
            blank_d  = blank_lz;
            dpm_d    = dp_mask;
            ovf_d    = 1'b0;
        end else if (conv_last) begin
            digits_d = bcd_shift;
            blank_d  = blank_sh_q;
            dpm_d    = dpm_sh_q;
            ovf_d    = ovf_sh_q | shift_out;
        end
    end

    always_comb begin
        presc_d = presc_q + PW'(1);
        idx_d   = idx_q;
        if (presc_q == PW'(SCAN_DIV - 1)) begin
            presc_d = '0;
            idx_d   = (idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + IW'(1);
        end
    end

    // A digit is a leading zero when it and every digit above it are zero
    always_comb begin
        seen      = 1'b0;
        lead_zero = '0;
        for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
            seen         = seen | (digits_q[4*i +: 4] != 4'd0);
            lead_zero[i] = !seen && (i != 0);
        end
    end

    always_comb begin
        sel_oh    = '0;
        cur_digit = '0;
        cur_dp    = 1'b0;
        cur_blank = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (IW'(i) == idx_q) begin
                sel_oh[i] = 1'b1;
                cur_digit = digits_q[4*i +: 4];
                cur_dp    = dpm_q[i];
                cur_blank = lead_zero[i];
            end
        end
        if (ovf_q) begin
            glyph = GLYPH_DASH;
        end else if (blank_q && cur_blank) begin
            glyph = GLYPH_BLANK;
        end else begin
            glyph = hex_glyph(cur_digit);
        end
        an_d  = sel_oh ^ {NUM_DIGITS{ACTIVE_LOW}};
        seg_d = glyph ^ {7{ACTIVE_LOW}};
        dp_d  = cur_dp ^ ACTIVE_LOW;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bin_q      <= '0;
            bcd_q      <= '0;
            ovf_sh_q   <= 1'b0;
            blank_sh_q <= 1'b0;
            dpm_sh_q   <= '0;
            iter_q     <= '0;
            digits_q   <= '0;
            blank_q    <= 1'b0;
            dpm_q      <= '0;
            ovf_q      <= 1'b0;
            presc_q    <= '0;
            idx_q      <= '0;
            an_q       <= {NUM_DIGITS{ACTIVE_LOW}};
            seg_q      <= {7{ACTIVE_LOW}};
            dp_q       <= ACTIVE_LOW;
        end else begin
            bin_q      <= bin_d;
            bcd_q      <= bcd_d;
            ovf_sh_q   <= ovf_sh_d;
            blank_sh_q <= blank_sh_d;
            dpm_sh_q   <= dpm_sh_d;
            iter_q     <= iter_d;
            digits_q   <= digits_d;
            blank_q    <= blank_d;
            dpm_q      <= dpm_d;
            ovf_q      <= ovf_d;
            presc_q    <= presc_d;
            idx_q      <= idx_d;
            an_q       <= an_d;
            seg_q      <= seg_d;
            dp_q       <= dp_d;
        end
    end

    assign an       = an_q;
    assign a_to_g   = seg_q;
    assign dp       = dp_q;
    assign busy     = (state_q == S_CONV);
    assign overflow = ovf_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: fixed vector table plus randomized loads checked against
// an arithmetic display model (digits via division, blanking via magnitude compare).
module tb_seg7_scan_driver;

    localparam int N  = 4;
    localparam int SD = 4;

    localparam logic [6:0] HEXG [16] = '{
        7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
        7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
    };

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] value;
    logic        load;
    logic        dec_mode;
    logic        blank_lz;
    logic [3:0]  dp_mask;
    logic [6:0]  a_to_g;
    logic [3:0]  an;
    logic        dp;
    logic        busy;
    logic        overflow;

    seg7_scan_driver #(
        .NUM_DIGITS(4),
        .SCAN_DIV  (4),
        .ACTIVE_LOW(1'b1)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .value   (value),
        .load    (load),
        .dec_mode(dec_mode),
        .blank_lz(blank_lz),
        .dp_mask (dp_mask),
        .a_to_g  (a_to_g),
        .an      (an),
        .dp      (dp),
        .busy    (busy),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Edges since reset release; selects the digit the scanner should be showing
    int scan_k = 0;
    always @(posedge clk) begin
        if (rst_n) scan_k <= 0;
        else       scan_k <= scan_k + 1;
    end

    logic [27:0] cur_glyphs;
    logic [3:0]  cur_dpm;
    logic        cur_ovf;

    typedef struct {
        int          v;
        bit          dec;
        bit          blank;
        logic [3:0]  dpm;
        bit          junk;
        logic [27:0] g;
        bit          ovf;
    } vec_t;

    vec_t tbl [10];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [27:0] model_glyphs(input int v, input bit dec, input bit blank);
        int          base;
        int          p;
        int          d;
        logic [6:0]  g;
        logic [27:0] r;
        base = dec ? 10 : 16;
        p    = 1;
        r    = '0;
        for (int i = 0; i < N; i++) begin
            d = (v / p) % base;
            if (dec && v > 9999)            g = 7'h01;
            else if (blank && i > 0 && v < p) g = 7'h00;
            else                            g = HEXG[d];
            r[7*i +: 7] = ~g;
            p = p * base;
        end
        return r;
    endfunction

    task automatic check_cycle(input logic [27:0] g, input logic [3:0] dpm,
                               input logic ovf, input logic bz);
        int         idx;
        logic [3:0] oh;
        logic [3:0] exp_an;
        logic [6:0] exp_seg;
        logic       exp_dp;
        idx     = ((scan_k - 1) / SD) % N;
        oh      = 4'b0001 << idx;
        exp_an  = ~oh;
        exp_seg = g[7*idx +: 7];
        exp_dp  = !dpm[idx];
        chk("an", 32'(an), 32'(exp_an));
        chk("a_to_g", 32'(a_to_g), 32'(exp_seg));
        chk("dp", 32'(dp), 32'(exp_dp));
        chk("busy", 32'(busy), 32'(bz));
        chk("overflow", 32'(overflow), 32'(ovf));
    endtask

    task automatic check_frame();
        for (int c = 0; c < N * SD; c++) begin
            check_cycle(cur_glyphs, cur_dpm, cur_ovf, 1'b0);
            tick();
        end
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b1;
        load  = 1'b0;
        for (int k = 0; k < n; k++) begin
            tick();
            chk("rst_an", 32'(an), 32'h0000_000F);
            chk("rst_seg", 32'(a_to_g), 32'h0000_007F);
            chk("rst_dp", 32'(dp), 32'h1);
            chk("rst_busy", 32'(busy), 32'h0);
            chk("rst_ovf", 32'(overflow), 32'h0);
        end
        rst_n      = 1'b0;
        cur_glyphs = {4{7'b0000001}};
        cur_dpm    = 4'b0000;
        cur_ovf    = 1'b0;
        tick();
        check_frame();
    endtask

    task automatic do_load(input int v, input bit dec, input bit blank, input logic [3:0] dpm,
                           input bit junk, input logic [27:0] exp_g, input bit exp_ovf);
        int nb;
        value    = 16'(v);
        dec_mode = dec;
        blank_lz = blank;
        dp_mask  = dpm;
        load     = 1'b1;
        tick();
        load     = 1'b0;
        value    = 16'($urandom);
        dec_mode = 1'($urandom);
        blank_lz = 1'($urandom);
        dp_mask  = 4'($urandom);
        nb = 0;
        while (busy && nb < 40) begin
            check_cycle(cur_glyphs, cur_dpm, cur_ovf, 1'b1);
            if (junk && nb == 4) begin
                value    = 16'h1111;
                dec_mode = 1'b0;
                blank_lz = 1'b1;
                dp_mask  = 4'hF;
                load     = 1'b1;
            end
            nb++;
            tick();
            load = 1'b0;
        end
        chk("busy_len", 32'(nb), dec ? 32'd16 : 32'd0);
        // Commit edge: overflow already updated, glyph still the old one
        check_cycle(cur_glyphs, cur_dpm, exp_ovf, 1'b0);
        cur_glyphs = exp_g;
        cur_dpm    = dpm;
        cur_ovf    = exp_ovf;
        tick();
        check_frame();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{32'h12AB, 1'b0, 1'b0, 4'b0000, 1'b0,
                   {7'b1001111, 7'b0010010, 7'b0001000, 7'b1100000}, 1'b0};
        tbl[1] = '{1234, 1'b1, 1'b0, 4'b0100, 1'b1,
                   {7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100}, 1'b0};
        tbl[2] = '{10000, 1'b1, 1'b0, 4'b0000, 1'b0, {4{7'b1111110}}, 1'b1};
        tbl[3] = '{0, 1'b0, 1'b0, 4'b0000, 1'b0, {4{7'b0000001}}, 1'b0};
        tbl[4] = '{32'h0050, 1'b0, 1'b1, 4'b0000, 1'b0,
                   {7'b1111111, 7'b1111111, 7'b0100100, 7'b0000001}, 1'b0};
        tbl[5] = '{0, 1'b0, 1'b1, 4'b0000, 1'b0,
                   {7'b1111111, 7'b1111111, 7'b1111111, 7'b0000001}, 1'b0};
        tbl[6] = '{9999, 1'b1, 1'b1, 4'b1001, 1'b0, {4{7'b0000100}}, 1'b0};
        tbl[7] = '{105, 1'b1, 1'b1, 4'b0010, 1'b1,
                   {7'b1111111, 7'b1001111, 7'b0000001, 7'b0100100}, 1'b0};
        tbl[8] = '{32'hFE0D, 1'b0, 1'b0, 4'b0000, 1'b0,
                   {7'b0111000, 7'b0110000, 7'b0000001, 7'b1000010}, 1'b0};
        tbl[9] = '{10000, 1'b1, 1'b1, 4'b1111, 1'b0, {4{7'b1111110}}, 1'b1};

        rst_n    = 1'b1;
        load     = 1'b0;
        value    = '0;
        dec_mode = 1'b0;
        blank_lz = 1'b0;
        dp_mask  = '0;

        do_reset(3);

        for (int r = 0; r < 10; r++) begin
            do_load(tbl[r].v, tbl[r].dec, tbl[r].blank, tbl[r].dpm, tbl[r].junk,
                    tbl[r].g, tbl[r].ovf);
        end

        // Reset arriving on the 5th busy cycle aborts the conversion without a commit
        value    = 16'd9999;
        dec_mode = 1'b1;
        blank_lz = 1'b0;
        dp_mask  = 4'b1111;
        load     = 1'b1;
        tick();
        load = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            chk("busy_pre_rst", 32'(busy), 32'h1);
            if (k < 5) tick();
        end
        do_reset(1);

        for (int r = 0; r < 24; r++) begin
            int          v;
            bit          dec;
            bit          blank;
            logic [3:0]  dpm;
            bit          junk;
            dec   = 1'($urandom_range(0, 1));
            blank = 1'($urandom_range(0, 1));
            dpm   = 4'($urandom);
            case ($urandom_range(0, 3))
                0:       v = $urandom_range(9990, 10010);
                1:       v = $urandom_range(0, 300);
                default: v = $urandom_range(0, 65535);
            endcase
            junk = dec && ($urandom_range(0, 2) == 0);
            do_load(v, dec, blank, dpm, junk, model_glyphs(v, dec, blank),
                    dec && (v > 9999));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
